uart_stream_arbiter: RTL and testbench
======================================

// Module: uart_stream_arbiter
// PURPOSE
//  Shares the single UART TX byte stream between two packet sources: req0 (image framer) and req1 (status/telemetry).
//  Grants are packet-granular: once granted, a source keeps the link until its beat with last=1 fires.
//  Output is a one-entry registered stage feeding the UART transmitter.
//  Optional watchdog revokes a grant from a stalled source.
// PARAMETERS
//  DataWidth      8  byte width of every data port
//  RoundRobin     1  1: alternate between sources at packet boundaries; 0: fixed priority, req0 wins
//  TimeoutCycles  0  granted-but-idle cycles before the grant is revoked; 0 disables the watchdog
//  PktCountWidth 16  width of the per-source packet counters (UART_ARB_PKT_COUNT_EN only)
// PORTS
//  clk_i         in   1              clock
//  rst_i         in   1              synchronous reset, active-high
//  valid0_i      in   1              req0 beat valid
//  ready0_o      out  1              req0 beat accepted
//  data0_i       in   DataWidth      req0 byte
//  last0_i       in   1              req0 final byte of packet
//  valid1_i/ready1_o/data1_i/last1_i                same as above, for req1
//  valid_o       out  1              output beat valid (registered)
//  ready_i       in   1              UART TX ready
//  data_o        out  DataWidth      output byte (registered)
//  last_o        out  1              output final-byte flag (registered)
//  grant_o       out  2              one-hot current owner; 0 when Idle
//  timeout_o     out  1              1-cycle pulse when the watchdog revokes a grant
// BEHAVIOUR
//  Reset: state=Idle, rr pointer favours req0, valid_o=0, data_o=0, last_o=0, grant_o=0, timeout_o=0,
//   watchdog=0. Reset mid-packet discards the in-flight beat in the output register.
//  FSM states Idle, Grant0, Grant1. Transitions:
//   Idle   -> GrantN on the next edge when validN_i=1.
//    Both valid: RoundRobin=1 picks the rr-pointer source; RoundRobin=0 picks req0.
//    No beat is accepted while in Idle, so each packet costs 1 bubble cycle.
//   GrantN -> Idle on the edge where the req N beat with lastN_i=1 fires.
//    The rr pointer moves to the other source on that same edge.
//   GrantN -> Idle on a watchdog expiry. timeout_o pulses; the rr pointer moves; no beat is emitted.
//  Handshake:
//   load = !valid_o || ready_i.
//   readyN_o = (state==GrantN) && load. The non-granted ready is always 0.
//   fireN = validN_i && readyN_o. On fireN the data/last register loads and valid_o<=1, so latency is 1 cycle.
//   On ready_i with no new fire, valid_o<=0. A simultaneous drain and load keeps valid_o=1 at full throughput.
//   data_o, valid_o and last_o hold stable while valid_o && !ready_i.
//   readyN_o never depends combinationally on validN_i.
//  Watchdog (TimeoutCycles>0):
//   Counter of width $clog2(TimeoutCycles+1). Clears on any fire and on entry to GrantN.
//   Increments while in GrantN with no fire.
//   Expiry at count==TimeoutCycles-1 with no fire that cycle. A fire in the expiry cycle wins and clears the counter.
//   A revoked packet is not terminated on the output: last_o is not synthesised. The downstream reframes on the tail bytes.
//  Boundary cases:
//   Single-beat packet (valid+last on the first granted cycle): one grant cycle, then Idle.
//   valid drops mid-packet: grant holds, and the watchdog counts (if enabled).
//   ready_i low for a long time: the watchdog still counts, because no source can fire.
//   grant_o is 0 in Idle and one-hot otherwise; it equals the state register.
// CONFIGURATION
//  UART_ARB_PKT_COUNT_EN defined:
//   adds outputs pkt_count0_o and pkt_count1_o, each PktCountWidth wide.
//   Each counter increments on fireN && lastN_i and wraps modulo 2^PktCountWidth.
//   Revoked packets are not counted. Both counters reset to 0.
//  Undefined: these ports and counters do not exist. All other behaviour is identical.
// TESTING
//  1. Only req0 sends a 4-byte packet, ready_i=1:
//     grant_o=01 one cycle after valid0; 4 output beats back-to-back; last_o on beat 4; then Idle.
//  2. RoundRobin=1, both sources hold 3-byte packets:
//     order req0,req1,req0,req1; 1 bubble between packets; no interleaving within a packet.
//  3. RoundRobin=0, both sources continuously valid: req1 never granted while req0 keeps requesting.
//  4. ready_i toggles 1010 during a packet:
//     data_o stable while stalled; no beat lost or duplicated; byte sequence matches input.
//  5. TimeoutCycles=8, req1 stalls after 2 bytes:
//     timeout_o pulses 8 cycles after the last fire; grant moves to req0; a pending req1 beat is not accepted.
//  6. Assert rst_i mid-packet with valid_o=1:
//     next cycle valid_o=0 and grant_o=0; UART_ARB_PKT_COUNT_EN counters are 0; after 2 full packets the counters read 1/1.

Source files
------------

// File: rtl/uart_stream_arbiter.sv
// Packet-granular two-source arbiter feeding a registered UART TX stage, with optional stall watchdog.
// Define UART_ARB_PKT_COUNT_EN to add the per-source completed-packet counters.
module uart_stream_arbiter #(
  parameter int DataWidth     = 8,
  parameter int RoundRobin    = 1,
  parameter int TimeoutCycles = 0,
  parameter int PktCountWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid0_i,
  output logic                 ready0_o,
  input  logic [DataWidth-1:0] data0_i,
  input  logic                 last0_i,
  input  logic                 valid1_i,
  output logic                 ready1_o,
  input  logic [DataWidth-1:0] data1_i,
  input  logic                 last1_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 last_o,
  output logic [1:0]           grant_o,
  output logic                 timeout_o
`ifdef UART_ARB_PKT_COUNT_EN
  ,
  output logic [PktCountWidth-1:0] pkt_count0_o,
  output logic [PktCountWidth-1:0] pkt_count1_o
`endif
);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    Idle   = 2'b00,
    Grant0 = 2'b01,
    Grant1 = 2'b10
  } state_e;

  localparam int WdW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  state_e               state_q, state_d;
  logic                 rr_q, rr_d;
  logic                 valid_q, valid_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic                 last_q, last_d;
  logic [WdW-1:0]       wd_q, wd_d;
  logic                 load, fire0, fire1, fire, expire;

  assign load     = !valid_q || ready_i;
  assign ready0_o = (state_q == Grant0) && load;
  assign ready1_o = (state_q == Grant1) && load;
  assign fire0    = valid0_i && ready0_o;
  assign fire1    = valid1_i && ready1_o;
  assign fire     = fire0 || fire1;

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign last_o    = last_q;
  assign grant_o   = state_q;
  assign timeout_o = expire;

  // A fire in the would-be expiry cycle takes precedence and restarts the count.
  always_comb begin
    wd_d   = '0;
    expire = 1'b0;
    if ((TimeoutCycles > 0) && (state_q != Idle) && !fire) begin
      if (wd_q == WdW'(TimeoutCycles - 1)) begin
        expire = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    case (state_q)
      Idle: begin
        if (valid0_i && valid1_i) begin
          state_d = ((RoundRobin != 0) && rr_q) ? Grant1 : Grant0;
        end else if (valid0_i) begin
          state_d = Grant0;
        end else if (valid1_i) begin
          state_d = Grant1;
        end
      end
      Grant0: begin
        if ((fire0 && last0_i) || expire) begin
          state_d = Idle;
          rr_d    = 1'b1;
        end
      end
      Grant1: begin
        if ((fire1 && last1_i) || expire) begin
          state_d = Idle;
          rr_d    = 1'b0;
        end
      end
      default: state_d = Idle;
    endcase
  end

  // Output stage holds its beat while the transmitter stalls.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (fire0) begin
      valid_d = 1'b1;
      data_d  = data0_i;
      last_d  = last0_i;
    end else if (fire1) begin
      valid_d = 1'b1;
      data_d  = data1_i;
      last_d  = last1_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Idle;
      rr_q    <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

`ifdef UART_ARB_PKT_COUNT_EN
  logic [PktCountWidth-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Only packets that finish with a last beat are counted; revoked ones never reach it.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (fire0 && last0_i) cnt0_d = cnt0_q + 1'b1;
    if (fire1 && last1_i) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign pkt_count0_o = cnt0_q;
  assign pkt_count1_o = cnt1_q;
`endif

endmodule

// File: tb/tb_uart_stream_arbiter.sv
// Directed bench: dutA is round-robin with an 8-cycle watchdog, dutB is fixed-priority without one.
module tb_uart_stream_arbiter;

  typedef struct {
    int rstBefore;
    int v0, l0, d0, v1, l1, d1, rdy;
    int evo, ed, el, eg, er0, er1, eto;
  } vecT;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid0, last0, valid1, last1, readyIn;
  logic [7:0] data0, data1;

  logic       aValid, aLast, aRdy0, aRdy1, aTo;
  logic [7:0] aData;
  logic [1:0] aGrant;
  logic       bValid, bLast, bRdy0, bRdy1, bTo;
  logic [7:0] bData;
  logic [1:0] bGrant;
`ifdef UART_ARB_PKT_COUNT_EN
  logic [15:0] aCnt0, aCnt1, bCnt0, bCnt1;
`endif

  int checks = 0;
  int errors = 0;
  vecT tab[$];

  always #5 clk = ~clk;

  uart_stream_arbiter #(.DataWidth(8), .RoundRobin(1), .TimeoutCycles(8), .PktCountWidth(16)) dutA (
    .clk_i(clk), .rst_i(rst),
    .valid0_i(valid0), .ready0_o(aRdy0), .data0_i(data0), .last0_i(last0),
    .valid1_i(valid1), .ready1_o(aRdy1), .data1_i(data1), .last1_i(last1),
    .valid_o(aValid), .ready_i(readyIn), .data_o(aData), .last_o(aLast),
    .grant_o(aGrant), .timeout_o(aTo)
`ifdef UART_ARB_PKT_COUNT_EN
    , .pkt_count0_o(aCnt0), .pkt_count1_o(aCnt1)
`endif
  );

  uart_stream_arbiter #(.DataWidth(8), .RoundRobin(0), .TimeoutCycles(0), .PktCountWidth(16)) dutB (
    .clk_i(clk), .rst_i(rst),
    .valid0_i(valid0), .ready0_o(bRdy0), .data0_i(data0), .last0_i(last0),
    .valid1_i(valid1), .ready1_o(bRdy1), .data1_i(data1), .last1_i(last1),
    .valid_o(bValid), .ready_i(readyIn), .data_o(bData), .last_o(bLast),
    .grant_o(bGrant), .timeout_o(bTo)
`ifdef UART_ARB_PKT_COUNT_EN
    , .pkt_count0_o(bCnt0), .pkt_count1_o(bCnt1)
`endif
  );

  function automatic vecT mkVec(input int rb, input int v0, input int l0, input int d0,
                                input int v1, input int l1, input int d1, input int rdy,
                                input int evo, input int ed, input int el, input int eg,
                                input int er0, input int er1, input int eto);
    vecT v;
    v.rstBefore = rb; v.v0 = v0; v.l0 = l0; v.d0 = d0; v.v1 = v1; v.l1 = l1; v.d1 = d1;
    v.rdy = rdy; v.evo = evo; v.ed = ed; v.el = el; v.eg = eg; v.er0 = er0; v.er1 = er1;
    v.eto = eto;
    return v;
  endfunction

  // Expected owner per cycle for two sources each sending two 3-byte packets.
  function automatic int expGrantRr(input int c);
    if (c == 0 || c >= 16) return 0;
    if (((c - 1) % 4) == 3) return 0;
    return ((((c - 1) / 4) % 2) == 0) ? 1 : 2;
  endfunction

  task automatic checkOutput(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    valid0 = 1'b0; valid1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
    data0 = 8'h00; data1 = 8'h00; readyIn = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input vecT v);
    valid0  = 1'(v.v0);
    last0   = 1'(v.l0);
    data0   = 8'(v.d0);
    valid1  = 1'(v.v1);
    last1   = 1'(v.l1);
    data1   = 8'(v.d1);
    readyIn = 1'(v.rdy);
  endtask

  task automatic checkVector(input int i, input vecT v);
    checkOutput($sformatf("v%0d valid_o", i), 32'(aValid), v.evo);
    if (v.evo != 0) begin
      checkOutput($sformatf("v%0d data_o", i), 32'(aData), v.ed);
      checkOutput($sformatf("v%0d last_o", i), 32'(aLast), v.el);
    end
    checkOutput($sformatf("v%0d grant_o", i), 32'(aGrant), v.eg);
    checkOutput($sformatf("v%0d ready0_o", i), 32'(aRdy0), v.er0);
    checkOutput($sformatf("v%0d ready1_o", i), 32'(aRdy1), v.er1);
    checkOutput($sformatf("v%0d timeout_o", i), 32'(aTo), v.eto);
  endtask

  task automatic sendPacket(input int src, input int len, input int base);
    for (int b = 0; b < len; b++) begin
      int  waited;
      bit  done;
      if (src == 0) begin
        valid0 = 1'b1; data0 = 8'(base + b); last0 = (b == len - 1);
      end else begin
        valid1 = 1'b1; data1 = 8'(base + b); last1 = (b == len - 1);
      end
      waited = 0;
      done   = 1'b0;
      while (!done && waited < 20) begin
        #4;
        done = (src == 0) ? aRdy0 : aRdy1;
        @(posedge clk); #1;
        waited++;
      end
      checkOutput($sformatf("t6 src%0d byte%0d accepted", src, b), 32'(done), 1);
    end
    valid0 = 1'b0; valid1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
  endtask

  initial begin
    int idx0, idx1, ridx;
    bit f0, f1;

    // Single 4-byte packet from req0 with the link always ready.
    tab.push_back(mkVec(1, 1,0,'hA0, 0,0,0, 1,  0,0,0,   0, 0,0,0));
    tab.push_back(mkVec(0, 1,0,'hA0, 0,0,0, 1,  0,0,0,   1, 1,0,0));
    tab.push_back(mkVec(0, 1,0,'hA1, 0,0,0, 1,  1,'hA0,0,1, 1,0,0));
    tab.push_back(mkVec(0, 1,0,'hA2, 0,0,0, 1,  1,'hA1,0,1, 1,0,0));
    tab.push_back(mkVec(0, 1,1,'hA3, 0,0,0, 1,  1,'hA2,0,1, 1,0,0));
    tab.push_back(mkVec(0, 0,0,0,    0,0,0, 1,  1,'hA3,1,0, 0,0,0));
    tab.push_back(mkVec(0, 0,0,0,    0,0,0, 1,  0,0,0,   0, 0,0,0));
    // Transmitter ready toggling mid-packet.
    tab.push_back(mkVec(1, 1,0,'hD0, 0,0,0, 1,  0,0,0,   0, 0,0,0));
    tab.push_back(mkVec(0, 1,0,'hD0, 0,0,0, 1,  0,0,0,   1, 1,0,0));
    tab.push_back(mkVec(0, 1,0,'hD1, 0,0,0, 0,  1,'hD0,0,1, 0,0,0));
    tab.push_back(mkVec(0, 1,0,'hD1, 0,0,0, 1,  1,'hD0,0,1, 1,0,0));
    tab.push_back(mkVec(0, 1,0,'hD2, 0,0,0, 0,  1,'hD1,0,1, 0,0,0));
    tab.push_back(mkVec(0, 1,0,'hD2, 0,0,0, 1,  1,'hD1,0,1, 1,0,0));
    tab.push_back(mkVec(0, 1,1,'hD3, 0,0,0, 0,  1,'hD2,0,1, 0,0,0));
    tab.push_back(mkVec(0, 1,1,'hD3, 0,0,0, 1,  1,'hD2,0,1, 1,0,0));
    tab.push_back(mkVec(0, 0,0,0,    0,0,0, 0,  1,'hD3,1,0, 0,0,0));
    tab.push_back(mkVec(0, 0,0,0,    0,0,0, 1,  1,'hD3,1,0, 0,0,0));
    tab.push_back(mkVec(0, 0,0,0,    0,0,0, 1,  0,0,0,   0, 0,0,0));
    // req1 stalls after two bytes; watchdog revokes and req0 wins the next arbitration.
    tab.push_back(mkVec(1, 0,0,0,    1,0,'hE0, 1, 0,0,0,   0, 0,0,0));
    tab.push_back(mkVec(0, 0,0,0,    1,0,'hE0, 1, 0,0,0,   2, 0,1,0));
    tab.push_back(mkVec(0, 0,0,0,    1,0,'hE1, 1, 1,'hE0,0,2, 0,1,0));
    tab.push_back(mkVec(0, 0,0,0,    0,0,0,    1, 1,'hE1,0,2, 0,1,0));
    for (int k = 0; k < 6; k++)
      tab.push_back(mkVec(0, 0,0,0,  0,0,0,    1, 0,0,0,   2, 0,1,0));
    tab.push_back(mkVec(0, 1,1,'hF0, 0,0,0,    1, 0,0,0,   2, 0,1,1));
    tab.push_back(mkVec(0, 1,1,'hF0, 1,0,'hE2, 1, 0,0,0,   0, 0,0,0));
    tab.push_back(mkVec(0, 1,1,'hF0, 1,0,'hE2, 1, 0,0,0,   1, 1,0,0));
    tab.push_back(mkVec(0, 0,0,0,    0,0,0,    1, 1,'hF0,1,0, 0,0,0));

    // Reset state, with both requests raised so the readies are observed low.
    doReset();
    valid0 = 1'b1; valid1 = 1'b1;
    #4;
    checkOutput("reset valid_o", 32'(aValid), 0);
    checkOutput("reset data_o", 32'(aData), 0);
    checkOutput("reset last_o", 32'(aLast), 0);
    checkOutput("reset grant_o", 32'(aGrant), 0);
    checkOutput("reset timeout_o", 32'(aTo), 0);
    checkOutput("reset ready0_o", 32'(aRdy0), 0);
    checkOutput("reset ready1_o", 32'(aRdy1), 0);
`ifdef UART_ARB_PKT_COUNT_EN
    checkOutput("reset pkt_count0", 32'(aCnt0), 0);
    checkOutput("reset pkt_count1", 32'(aCnt1), 0);
`endif

    foreach (tab[i]) begin
      if (tab[i].rstBefore != 0) doReset();
      applyStimulus(tab[i]);
      #4;
      checkVector(i, tab[i]);
      @(posedge clk); #1;
    end

    // Round robin: two 3-byte packets per source, alternating with one bubble each.
    doReset();
    idx0 = 0; idx1 = 0; ridx = 0;
    for (int c = 0; c < 19; c++) begin
      valid0 = (idx0 < 6); data0 = 8'(8'h10 + idx0); last0 = ((idx0 % 3) == 2);
      valid1 = (idx1 < 6); data1 = 8'(8'h80 + idx1); last1 = ((idx1 % 3) == 2);
      #4;
      checkOutput($sformatf("t2 c%0d grant_o", c), 32'(aGrant), expGrantRr(c));
      if (aValid && readyIn) begin
        if (ridx < 12) begin
          int pkt, expD;
          pkt  = ridx / 3;
          expD = (((pkt % 2) == 0) ? 'h10 : 'h80) + (pkt / 2) * 3 + (ridx % 3);
          checkOutput($sformatf("t2 beat%0d data_o", ridx), 32'(aData), expD);
          checkOutput($sformatf("t2 beat%0d last_o", ridx), 32'(aLast), ((ridx % 3) == 2) ? 1 : 0);
        end
        ridx++;
      end
      f0 = valid0 && aRdy0;
      f1 = valid1 && aRdy1;
      @(posedge clk); #1;
      if (f0) idx0++;
      if (f1) idx1++;
    end
    checkOutput("t2 beat count", ridx, 12);

    // Fixed priority on dutB: req0 always requesting starves req1.
    doReset();
    idx0 = 0;
    for (int c = 0; c < 21; c++) begin
      valid0 = 1'b1; data0 = 8'(idx0); last0 = ((idx0 % 2) == 1);
      valid1 = 1'b1; data1 = 8'hBB; last1 = 1'b1;
      #4;
      checkOutput($sformatf("t3 c%0d grant_o", c), 32'(bGrant), ((c % 3) == 0) ? 0 : 1);
      checkOutput($sformatf("t3 c%0d ready1_o", c), 32'(bRdy1), 0);
      f0 = bRdy0;
      @(posedge clk); #1;
      if (f0) idx0++;
    end

    // Reset while a beat sits in the output register.
    doReset();
    valid0 = 1'b1; data0 = 8'h55; last0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #4;
    checkOutput("t6 pre-reset valid_o", 32'(aValid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; valid0 = 1'b0;
    #4;
    checkOutput("t6 post-reset valid_o", 32'(aValid), 0);
    checkOutput("t6 post-reset grant_o", 32'(aGrant), 0);
`ifdef UART_ARB_PKT_COUNT_EN
    checkOutput("t6 post-reset pkt_count0", 32'(aCnt0), 0);
    checkOutput("t6 post-reset pkt_count1", 32'(aCnt1), 0);
`endif
    @(posedge clk); #1;
    sendPacket(0, 2, 'h60);
    sendPacket(1, 2, 'h70);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t6 final grant_o", 32'(aGrant), 0);
    checkOutput("t6 final valid_o", 32'(aValid), 0);
`ifdef UART_ARB_PKT_COUNT_EN
    checkOutput("t6 pkt_count0", 32'(aCnt0), 1);
    checkOutput("t6 pkt_count1", 32'(aCnt1), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global timeout reached");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
